// File: rtl/conv_window_gen.sv
// conv_window_gen: raster pixel stream -> 3x3 valid-mode windows for the conv engine.
// Optional: define CONV_WIN_CNT_EN to add the per-frame window counter output win_cnt.
module conv_window_gen #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        busy,
  output logic [7:0]  win1,
  output logic [7:0]  win2,
  output logic [7:0]  win3,
  output logic [7:0]  win4,
  output logic [7:0]  win5,
  output logic [7:0]  win6,
  output logic [7:0]  win7,
  output logic [7:0]  win8,
  output logic [7:0]  win9,
  output logic        win_valid,
  output logic        frame_done
`ifdef CONV_WIN_CNT_EN
  ,
  output logic [15:0] win_cnt
`endif
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] col, col_nxt;
  logic [RW-1:0] row, row_nxt;
  logic          accept;
  logic          last_pix;
  logic          win_ok;

  logic [7:0] lb0 [IMG_W];
  logic [7:0] lb1 [IMG_W];
  logic [7:0] top_px;
  logic [7:0] mid_px;

  // The two most recent columns of each window row; the third column is the incoming one.
  logic [7:0] hist    [3][2];
  logic [7:0] win_nxt [9];
  logic [7:0] win_q   [9];

  assign last_pix = (col == COL_LAST) && (row == ROW_LAST);
  assign win_ok   = (row >= RW'(2)) && (col >= CW'(2));
  assign busy     = (state == RUN);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    row_nxt   = row;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          col_nxt   = '0;
          row_nxt   = '0;
        end
      end
      RUN: begin
        if (in_valid) begin
          accept = 1'b1;
          if (col == COL_LAST) begin
            col_nxt = '0;
            row_nxt = (row == ROW_LAST) ? '0 : row + 1'b1;
          end else begin
            col_nxt = col + 1'b1;
          end
          if (last_pix) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    top_px = lb1[col];
    mid_px = lb0[col];
    for (int r = 0; r < 3; r++) begin
      win_nxt[3*r]     = hist[r][0];
      win_nxt[3*r + 1] = hist[r][1];
    end
    win_nxt[2] = top_px;
    win_nxt[5] = mid_px;
    win_nxt[8] = in_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      hist       <= '{default: '0};
      win_q      <= '{default: '0};
    end else begin
      state      <= state_nxt;
      col        <= col_nxt;
      row        <= row_nxt;
      win_valid  <= accept && win_ok;
      frame_done <= accept && last_pix;
      if (accept) begin
        for (int r = 0; r < 3; r++) hist[r][0] <= hist[r][1];
        hist[0][1] <= top_px;
        hist[1][1] <= mid_px;
        hist[2][1] <= in_data;
        // Outputs only load on complete windows, so row-boundary stale columns never appear.
        if (win_ok) win_q <= win_nxt;
      end
    end
  end

  // NOTE: line buffers carry no reset; each frame rewrites a column before it ever feeds a valid window.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[col] <= lb0[col];
      lb0[col] <= in_data;
    end
  end

`ifdef CONV_WIN_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_cnt <= '0;
    end else if (state == IDLE && start) begin
      win_cnt <= '0;
    end else if (accept && win_ok) begin
      win_cnt <= win_cnt + 16'd1;
    end
  end
`endif

  assign win1 = win_q[0];
  assign win2 = win_q[1];
  assign win3 = win_q[2];
  assign win4 = win_q[3];
  assign win5 = win_q[4];
  assign win6 = win_q[5];
  assign win7 = win_q[6];
  assign win8 = win_q[7];
  assign win9 = win_q[8];

endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: a 4x4 and a 5x3 instance checked against a frame-buffer model.
`timescale 1ns/1ps
module tb_conv_window_gen;

  localparam int AW = 4;
  localparam int AH = 4;
  localparam int BW = 5;
  localparam int BH = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;

  logic busy_a, wv_a, fd_a;
  logic busy_b, wv_b, fd_b;
  logic [8:0][7:0] wa, wb;
`ifdef CONV_WIN_CNT_EN
  logic [15:0] cnt_a, cnt_b;
`endif

  always #5 clk = ~clk;

  conv_window_gen #(.IMG_W(AW), .IMG_H(AH)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .in_valid(in_valid), .in_data(in_data),
    .busy(busy_a),
    .win1(wa[0]), .win2(wa[1]), .win3(wa[2]), .win4(wa[3]), .win5(wa[4]),
    .win6(wa[5]), .win7(wa[6]), .win8(wa[7]), .win9(wa[8]),
    .win_valid(wv_a), .frame_done(fd_a)
`ifdef CONV_WIN_CNT_EN
    , .win_cnt(cnt_a)
`endif
  );

  conv_window_gen #(.IMG_W(BW), .IMG_H(BH)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .in_valid(in_valid), .in_data(in_data),
    .busy(busy_b),
    .win1(wb[0]), .win2(wb[1]), .win3(wb[2]), .win4(wb[3]), .win5(wb[4]),
    .win6(wb[5]), .win7(wb[6]), .win8(wb[7]), .win9(wb[8]),
    .win_valid(wv_b), .frame_done(fd_b)
`ifdef CONV_WIN_CNT_EN
    , .win_cnt(cnt_b)
`endif
  );

  logic sel = 1'b0;
  logic s_busy, s_wv, s_fd;
  logic [8:0][7:0] s_win;
  assign s_busy = sel ? busy_b : busy_a;
  assign s_wv   = sel ? wv_b : wv_a;
  assign s_fd   = sel ? fd_b : fd_a;
  assign s_win  = sel ? wb : wa;
`ifdef CONV_WIN_CNT_EN
  logic [15:0] s_cnt;
  assign s_cnt = sel ? cnt_b : cnt_a;
`endif

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [71:0] mkw(input int a, input int b, input int c, input int d,
                                      input int e, input int f, input int g, input int h,
                                      input int i);
    logic [8:0][7:0] w;
    w[0] = 8'(a); w[1] = 8'(b); w[2] = 8'(c);
    w[3] = 8'(d); w[4] = 8'(e); w[5] = 8'(f);
    w[6] = 8'(g); w[7] = 8'(h); w[8] = 8'(i);
    return w;
  endfunction

  // Model: store every accepted pixel of the frame, cut windows out of the stored image.
  logic [7:0] img [0:63];
  int m_w = AW;
  int m_h = AH;
  int m_idx = 0;
  bit m_run = 1'b0;
  bit exp_valid = 1'b0;
  bit exp_done = 1'b0;
  logic [8:0][7:0] exp_win = '0;
  int exp_cnt = 0;

  task automatic model_step();
    int r, c;
    if (rst) begin
      m_run = 1'b0; exp_valid = 1'b0; exp_done = 1'b0; exp_win = '0; exp_cnt = 0;
      return;
    end
    exp_valid = 1'b0;
    exp_done  = 1'b0;
    if (!m_run) begin
      if ((sel ? start_b : start_a) == 1'b1) begin
        m_run = 1'b1; m_idx = 0; exp_cnt = 0;
      end
    end else if (in_valid) begin
      r = m_idx / m_w;
      c = m_idx % m_w;
      img[6'(m_idx)] = in_data;
      if (r >= 2 && c >= 2) begin
        exp_valid = 1'b1;
        exp_cnt++;
        for (int k = 0; k < 9; k++)
          exp_win[k] = img[6'((r - 2 + k / 3) * m_w + (c - 2 + k % 3))];
      end
      m_idx++;
      if (m_idx == m_w * m_h) begin
        exp_done = 1'b1;
        m_run = 1'b0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  logic [71:0] got_q[$];
  bit got_done[$];

  initial forever begin
    @(negedge clk);
    check("busy", 72'(s_busy), 72'(m_run));
    check("win_valid", 72'(s_wv), 72'(exp_valid));
    check("frame_done", 72'(s_fd), 72'(exp_done));
    check("window", s_win, exp_win);
`ifdef CONV_WIN_CNT_EN
    check("win_cnt", 72'(s_cnt), 72'(exp_cnt));
`endif
    if (s_wv) begin
      got_q.push_back(s_win);
      got_done.push_back(s_fd);
    end
  end

  function automatic logic [7:0] pix(input int base, input int i);
    if (base < 0) return (i % 2 == 0) ? 8'd255 : 8'd0;
    return 8'(base + i);
  endfunction

  task automatic set_start(input bit v);
    if (sel) start_b = v;
    else start_a = v;
  endtask

  task automatic drive_frame(input int base, input int n, input int stall_mod,
                             input bit do_start, input int mid_start, input bit bb);
    int i = 0;
    int cyc = 0;
    if (do_start) begin
      @(negedge clk);
      set_start(1'b1);
      in_valid = 1'b1;
      in_data = 8'h55;
    end
    while (i < n) begin
      @(negedge clk);
      set_start(1'b0);
      cyc++;
      if (stall_mod > 0 && cyc % stall_mod == 0) begin
        in_valid = 1'b0;
        in_data = 8'hEE;
      end else begin
        in_valid = 1'b1;
        in_data = pix(base, i);
        if (i == mid_start) set_start(1'b1);
        i++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    set_start(bb);
    if (bb) check("frame_done_at_b2b_start", 72'(s_fd), 72'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      set_start(1'b0);
    end
  endtask

  task automatic clear_got();
    got_q.delete();
    got_done.delete();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_busy", 72'(s_busy), 72'd0);
    check("reset_win_valid", 72'(s_wv), 72'd0);
    check("reset_frame_done", 72'(s_fd), 72'd0);
    check("reset_window", s_win, 72'd0);
    #1 rst = 1'b0;

    // Plain 4x4 frame of 0..15.
    clear_got();
    drive_frame(0, 16, 0, 1'b1, -1, 1'b0);
    idle(3);
    check("s1_count", 72'(got_q.size()), 72'd4);
    if (got_q.size() == 4) begin
      check("s1_first", got_q[0], mkw(0, 1, 2, 4, 5, 6, 8, 9, 10));
      check("s1_last", got_q[3], mkw(5, 6, 7, 9, 10, 11, 13, 14, 15));
      check("s1_last_done", 72'(got_done[3]), 72'd1);
      check("s1_first_not_done", 72'(got_done[0]), 72'd0);
    end
    check("s1_busy_after", 72'(s_busy), 72'd0);
`ifdef CONV_WIN_CNT_EN
    check("s1_cnt_total", 72'(s_cnt), 72'd4);
`endif

    // Same frame with every third cycle stalled.
    clear_got();
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
`ifdef CONV_WIN_CNT_EN
    check("s2_cnt_cleared", 72'(s_cnt), 72'd0);
`endif
    drive_frame(0, 16, 3, 1'b0, -1, 1'b0);
    idle(3);
    check("s2_count", 72'(got_q.size()), 72'd4);
    if (got_q.size() == 4) begin
      check("s2_first", got_q[0], mkw(0, 1, 2, 4, 5, 6, 8, 9, 10));
      check("s2_second", got_q[1], mkw(1, 2, 3, 5, 6, 7, 9, 10, 11));
      check("s2_last", got_q[3], mkw(5, 6, 7, 9, 10, 11, 13, 14, 15));
    end

    // Pixels offered while idle must be ignored.
    clear_got();
    repeat (3) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data = 8'h77;
    end
    drive_frame(0, 16, 0, 1'b1, -1, 1'b0);
    idle(3);
    check("s3_count", 72'(got_q.size()), 72'd4);
    if (got_q.size() == 4)
      check("s3_first", got_q[0], mkw(0, 1, 2, 4, 5, 6, 8, 9, 10));

    // start pulsed mid-frame is ignored.
    clear_got();
    drive_frame(0, 16, 0, 1'b1, 6, 1'b0);
    idle(3);
    check("s4_count", 72'(got_q.size()), 72'd4);
    if (got_q.size() == 4) begin
      check("s4_last", got_q[3], mkw(5, 6, 7, 9, 10, 11, 13, 14, 15));
      check("s4_last_done", 72'(got_done[3]), 72'd1);
    end

    // Reset after pixel 9, then a fresh frame of 100..115.
    drive_frame(0, 10, 0, 1'b1, -1, 1'b0);
    check("s5_busy_before_rst", 72'(s_busy), 72'd1);
    #1 rst = 1'b1;
    @(negedge clk);
    check("s5_rst_busy", 72'(s_busy), 72'd0);
    check("s5_rst_win_valid", 72'(s_wv), 72'd0);
    check("s5_rst_window", s_win, 72'd0);
    #1 rst = 1'b0;
    clear_got();
    drive_frame(100, 16, 0, 1'b1, -1, 1'b0);
    idle(3);
    check("s5_count", 72'(got_q.size()), 72'd4);
    if (got_q.size() == 4)
      check("s5_first", got_q[0], mkw(100, 101, 102, 104, 105, 106, 108, 109, 110));

    // 5x3 instance: 255/0 checkerboard, two frames back to back.
    @(negedge clk);
    #1 rst = 1'b1;
    sel = 1'b1;
    m_w = BW;
    m_h = BH;
    @(negedge clk);
    #1 rst = 1'b0;
    clear_got();
    drive_frame(-1, 15, 0, 1'b1, -1, 1'b1);
    drive_frame(-1, 15, 0, 1'b0, -1, 1'b0);
    idle(3);
    check("s6_count", 72'(got_q.size()), 72'd6);
    if (got_q.size() == 6) begin
      check("s6_w0", got_q[0], mkw(255, 0, 255, 0, 255, 0, 255, 0, 255));
      check("s6_w1", got_q[1], mkw(0, 255, 0, 255, 0, 255, 0, 255, 0));
      check("s6_w2", got_q[2], mkw(255, 0, 255, 0, 255, 0, 255, 0, 255));
      check("s6_w2_done", 72'(got_done[2]), 72'd1);
      check("s6_w3_b2b", got_q[3], mkw(255, 0, 255, 0, 255, 0, 255, 0, 255));
      check("s6_w5_done", 72'(got_done[5]), 72'd1);
    end
    check("s6_busy_after", 72'(s_busy), 72'd0);
`ifdef CONV_WIN_CNT_EN
    check("s6_cnt_total", 72'(s_cnt), 72'd3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
